id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the opcode decoder.
- Latches the decoder's control bundle, register-file read data, sign-extended immediate, register specifiers and PC+4 for the EX stage.
- Includes load-use hazard detection: produces a stall to the PC and IF/ID register and inserts a bubble into EX.
- Supports flush on taken branch/jump, and keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- DATA_WIDTH, 32, width of operand, immediate and PC paths
- REG_ADDR_WIDTH, 5, width of register specifiers
- CNT_WIDTH, 16, width of the bubble counter

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset; synchronous, active-high
- Flush  in  1  squash the instruction currently in ID (branch taken / jump resolved)
- RegDst_in  in  2  decoder control
- Jump_in, Branch_in, MemRead_in, MemtoReg_in, RegWrite_in, ALUSrc_in, Double_in, D_addi_in  in  1 each  decoder controls
- ALUOp_in  in  3  decoder ALU op class
- ReadData1_in, ReadData2_in  in  DATA_WIDTH  register-file outputs
- Imm_in  in  DATA_WIDTH  sign-extended immediate
- PCPlus4_in  in  DATA_WIDTH  PC+4 of the ID instruction
- Rs_in, Rt_in, Rd_in  in  REG_ADDR_WIDTH  register specifiers of the ID instruction
- RegDst_ex, ALUOp_ex, and every other *_in  out  same width  registered copies, same names with suffix _ex
- Valid_ex  out  1  EX holds a real instruction, not a bubble
- Stall  out  1  combinational; holds PC and IF/ID this cycle
- BubbleCount  out  CNT_WIDTH  saturating count of bubbles inserted

Behaviour:
- Reset (Rst high at edge):
  - All _ex outputs cleared to 0.
  - Valid_ex=0 and BubbleCount=0.
  - Rst dominates Flush and hazard.
  - Stall is forced 0 while Rst is high.
- Hazard term: Hz = MemRead_ex & Valid_ex & (Rt_ex != 0) & ((Rt_ex == Rs_in) | ((Rt_ex == Rt_in) & ~ALUSrc_in)).
  - Rt_in counts as a source only when ALUSrc_in=0 (R-type, mul, beq, bne, addj).
- Stall = Hz & ~Flush & ~Rst. It is combinational from the current inputs and registers, with zero-cycle latency.
- Edge priority, highest first:
  1. Rst: clear everything.
  2. Flush: load a bubble, then increment BubbleCount.
  3. Hz: load a bubble, then increment BubbleCount.
  4. Otherwise capture all _in values into _ex and set Valid_ex=1.
- Bubble contents:
  - Jump, Branch, MemRead, MemtoReg, RegWrite, Double, D_addi = 0.
  - ALUOp=000, ALUSrc=0, RegDst=00.
  - Data, immediate, PC and specifier fields = 0.
  - Valid_ex=0.
- Flush and Hz in the same cycle: exactly one bubble and one count increment; Stall=0 because the ID instruction is squashed and IF/ID reloads.
- Latency: one cycle ID->EX for non-bubbled instructions.
- A load-use case stalls for exactly one cycle. After the bubble, Valid_ex=0, so Hz deasserts and the held instruction is captured at the next edge.
- BubbleCount saturates at 2^CNT_WIDTH-1; it never wraps.
- Reset mid-stall: the bubble is discarded; after reset the held IF/ID instruction is captured normally (Valid_ex=0 means no hazard).
- No other state exists. The block contains no FSM beyond the pipeline register and counter.

Test Plan:
- Reset: Rst=1 for 2 cycles with random inputs -> all _ex=0, Valid_ex=0, Stall=0, BubbleCount=0.
- Pass-through: addi with RegWrite_in=1, ALUSrc_in=1, ALUOp_in=010, ReadData1_in=0x10, Imm_in=5, Rt_in=8 -> after one edge the _ex values match, Valid_ex=1, Stall=0.
- Load-use: lw (MemRead_in=1, Rt_in=8) captured at edge N; add with Rs_in=8 in ID -> Stall=1 during cycle N+1, bubble at edge N+1 (RegWrite_ex=0, Valid_ex=0, BubbleCount=1), Stall=0 in cycle N+2, add captured at edge N+2.
- No false hazard, two cases, each -> Stall=0, no bubble:
  - lw to Rt=0 followed by Rs_in=0.
  - lw to Rt=8 followed by addi with Rs_in=9, Rt_in=8, ALUSrc_in=1.
- Flush with hazard: the load-use setup above plus Flush=1 in cycle N+1 -> Stall=0, one bubble, BubbleCount increments by exactly 1.
- Saturation: CNT_WIDTH=4, 20 consecutive Flush cycles -> BubbleCount reaches 15 and holds; a Rst edge returns it to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register that sits directly after the opcode decoder. It
// holds the decoder control bundle, the register-file read data, the
// sign-extended immediate, the register specifiers and PC+4 of the
// instruction that moves into EX.
//
// It also detects load-use hazards. When the instruction in EX is a load
// whose destination is a source of the instruction in ID, Stall is raised for
// one cycle to hold the PC and IF/ID, and a bubble enters EX. A Flush from a
// resolved branch or jump squashes the ID instruction into a bubble as well.
// Every bubble that enters EX is counted in a saturating counter for
// performance debug.
//
// Parameters
//   DATA_WIDTH      width of the operand, immediate and PC paths
//   REG_ADDR_WIDTH  width of the register specifiers
//   CNT_WIDTH       width of the bubble counter
//
// Ports
//   Clk, Rst               clock and synchronous active-high reset
//   Flush                  squash the instruction currently in ID
//   *_in                   decoder controls, operands, immediate, PC+4 and
//                          register specifiers of the ID instruction
//   *_ex                   registered copies of the *_in values for EX
//   Valid_ex               EX holds a real instruction, not a bubble
//   Stall                  combinational; holds PC and IF/ID this cycle
//   BubbleCount            saturating count of inserted bubbles
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Flush,

    input  logic [1:0]                RegDst_in,
    input  logic                      Jump_in,
    input  logic                      Branch_in,
    input  logic                      MemRead_in,
    input  logic                      MemtoReg_in,
    input  logic                      RegWrite_in,
    input  logic                      ALUSrc_in,
    input  logic                      Double_in,
    input  logic                      D_addi_in,
    input  logic [2:0]                ALUOp_in,
    input  logic [DATA_WIDTH-1:0]     ReadData1_in,
    input  logic [DATA_WIDTH-1:0]     ReadData2_in,
    input  logic [DATA_WIDTH-1:0]     Imm_in,
    input  logic [DATA_WIDTH-1:0]     PCPlus4_in,
    input  logic [REG_ADDR_WIDTH-1:0] Rs_in,
    input  logic [REG_ADDR_WIDTH-1:0] Rt_in,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_in,

    output logic [1:0]                RegDst_ex,
    output logic                      Jump_ex,
    output logic                      Branch_ex,
    output logic                      MemRead_ex,
    output logic                      MemtoReg_ex,
    output logic                      RegWrite_ex,
    output logic                      ALUSrc_ex,
    output logic                      Double_ex,
    output logic                      D_addi_ex,
    output logic [2:0]                ALUOp_ex,
    output logic [DATA_WIDTH-1:0]     ReadData1_ex,
    output logic [DATA_WIDTH-1:0]     ReadData2_ex,
    output logic [DATA_WIDTH-1:0]     Imm_ex,
    output logic [DATA_WIDTH-1:0]     PCPlus4_ex,
    output logic [REG_ADDR_WIDTH-1:0] Rs_ex,
    output logic [REG_ADDR_WIDTH-1:0] Rt_ex,
    output logic [REG_ADDR_WIDTH-1:0] Rd_ex,

    output logic                      Valid_ex,
    output logic                      Stall,
    output logic [CNT_WIDTH-1:0]      BubbleCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------------
    logic rt_ex_nonzero;
    logic rs_uses_load;
    logic rt_uses_load;
    logic hazard;
    logic insert_bubble;

    // Register 0 is hardwired to zero, so a load that targets it cannot
    // create a dependency. Rt of the ID instruction is only a source when it
    // takes its second operand from the register file (ALUSrc_in = 0); for
    // immediate forms Rt is a destination and must not trigger a stall.
    always_comb begin
        rt_ex_nonzero = |Rt_ex;
        rs_uses_load  = (Rt_ex == Rs_in);
        rt_uses_load  = (Rt_ex == Rt_in) & ~ALUSrc_in;
        hazard        = MemRead_ex & Valid_ex & rt_ex_nonzero
                        & (rs_uses_load | rt_uses_load);
    end

    // A flush squashes the ID instruction, so IF/ID is reloaded anyway and
    // holding it would be wrong. Reset also overrides the stall.
    always_comb begin
        Stall         = hazard & ~Flush & ~Rst;
        insert_bubble = Flush | hazard;
    end

    // ------------------------------------------------------------------------
    // Pipeline register payload
    // ------------------------------------------------------------------------
    // A bubble is encoded as an all-zero payload: no register write, no
    // memory access, no branch/jump, so EX/MEM/WB treat it as a no-op even
    // before Valid_ex is consulted.
    always_ff @(posedge Clk) begin
        if (Rst || insert_bubble) begin
            RegDst_ex    <= '0;
            Jump_ex      <= 1'b0;
            Branch_ex    <= 1'b0;
            MemRead_ex   <= 1'b0;
            MemtoReg_ex  <= 1'b0;
            RegWrite_ex  <= 1'b0;
            ALUSrc_ex    <= 1'b0;
            Double_ex    <= 1'b0;
            D_addi_ex    <= 1'b0;
            ALUOp_ex     <= '0;
            ReadData1_ex <= '0;
            ReadData2_ex <= '0;
            Imm_ex       <= '0;
            PCPlus4_ex   <= '0;
            Rs_ex        <= '0;
            Rt_ex        <= '0;
            Rd_ex        <= '0;
        end else begin
            RegDst_ex    <= RegDst_in;
            Jump_ex      <= Jump_in;
            Branch_ex    <= Branch_in;
            MemRead_ex   <= MemRead_in;
            MemtoReg_ex  <= MemtoReg_in;
            RegWrite_ex  <= RegWrite_in;
            ALUSrc_ex    <= ALUSrc_in;
            Double_ex    <= Double_in;
            D_addi_ex    <= D_addi_in;
            ALUOp_ex     <= ALUOp_in;
            ReadData1_ex <= ReadData1_in;
            ReadData2_ex <= ReadData2_in;
            Imm_ex       <= Imm_in;
            PCPlus4_ex   <= PCPlus4_in;
            Rs_ex        <= Rs_in;
            Rt_ex        <= Rt_in;
            Rd_ex        <= Rd_in;
        end
    end

    // ------------------------------------------------------------------------
    // Valid flag
    // ------------------------------------------------------------------------
    // A bubble clears Valid_ex, which also breaks the hazard term on the
    // next cycle so a stalled instruction is captured after exactly one
    // bubble. After a reset Valid_ex is 0 for the same reason, so an
    // instruction held in IF/ID across a reset is captured normally.
    always_ff @(posedge Clk) begin
        if (Rst || insert_bubble) begin
            Valid_ex <= 1'b0;
        end else begin
            Valid_ex <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating bubble counter
    // ------------------------------------------------------------------------
    // Flush and hazard in the same cycle produce a single bubble and
    // therefore a single increment. The counter sticks at its maximum so a
    // long run never wraps back to a misleadingly small value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            BubbleCount <= '0;
        end else if (insert_bubble && (BubbleCount != CNT_MAX)) begin
            BubbleCount <= BubbleCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. Two instances share the same stimulus:
// one with the default 16-bit bubble counter and one with a 4-bit counter so
// that saturation is reachable in a few cycles. A behavioural model tracks
// what EX should hold, whether a bubble is due and how many bubbles have
// been inserted; directed steps come first, followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic [1:0]  regdst;
        logic        jump;
        logic        branch;
        logic        memread;
        logic        memtoreg;
        logic        regwrite;
        logic        alusrc;
        logic        dbl;
        logic        daddi;
        logic [2:0]  aluop;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    logic   Clk = 1'b0;
    logic   Rst;
    logic   Flush;
    instr_t inBus;

    // Main instance outputs
    logic [1:0]  RegDst_ex;
    logic        Jump_ex, Branch_ex, MemRead_ex, MemtoReg_ex, RegWrite_ex;
    logic        ALUSrc_ex, Double_ex, D_addi_ex;
    logic [2:0]  ALUOp_ex;
    logic [31:0] ReadData1_ex, ReadData2_ex, Imm_ex, PCPlus4_ex;
    logic [4:0]  Rs_ex, Rt_ex, Rd_ex;
    logic        Valid_ex, Stall;
    logic [15:0] BubbleCount;

    // Small-counter instance outputs
    logic [1:0]  sRegDst_ex;
    logic        sJump_ex, sBranch_ex, sMemRead_ex, sMemtoReg_ex, sRegWrite_ex;
    logic        sALUSrc_ex, sDouble_ex, sD_addi_ex;
    logic [2:0]  sALUOp_ex;
    logic [31:0] sReadData1_ex, sReadData2_ex, sImm_ex, sPCPlus4_ex;
    logic [4:0]  sRs_ex, sRt_ex, sRd_ex;
    logic        sValid_ex, sStall;
    logic [3:0]  sBubbleCount;

    // Reference model state
    instr_t expEx;
    logic   expValid;
    int     expBubbles;
    logic   expStall;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    always #5 Clk = ~Clk;

    id_ex_stage dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .RegDst_in(inBus.regdst), .Jump_in(inBus.jump), .Branch_in(inBus.branch),
        .MemRead_in(inBus.memread), .MemtoReg_in(inBus.memtoreg),
        .RegWrite_in(inBus.regwrite), .ALUSrc_in(inBus.alusrc),
        .Double_in(inBus.dbl), .D_addi_in(inBus.daddi), .ALUOp_in(inBus.aluop),
        .ReadData1_in(inBus.rd1), .ReadData2_in(inBus.rd2), .Imm_in(inBus.imm),
        .PCPlus4_in(inBus.pc4), .Rs_in(inBus.rs), .Rt_in(inBus.rt), .Rd_in(inBus.rd),
        .RegDst_ex(RegDst_ex), .Jump_ex(Jump_ex), .Branch_ex(Branch_ex),
        .MemRead_ex(MemRead_ex), .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex),
        .ALUSrc_ex(ALUSrc_ex), .Double_ex(Double_ex), .D_addi_ex(D_addi_ex),
        .ALUOp_ex(ALUOp_ex), .ReadData1_ex(ReadData1_ex), .ReadData2_ex(ReadData2_ex),
        .Imm_ex(Imm_ex), .PCPlus4_ex(PCPlus4_ex), .Rs_ex(Rs_ex), .Rt_ex(Rt_ex),
        .Rd_ex(Rd_ex), .Valid_ex(Valid_ex), .Stall(Stall), .BubbleCount(BubbleCount)
    );

    id_ex_stage #(.CNT_WIDTH(4)) dutSmall (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .RegDst_in(inBus.regdst), .Jump_in(inBus.jump), .Branch_in(inBus.branch),
        .MemRead_in(inBus.memread), .MemtoReg_in(inBus.memtoreg),
        .RegWrite_in(inBus.regwrite), .ALUSrc_in(inBus.alusrc),
        .Double_in(inBus.dbl), .D_addi_in(inBus.daddi), .ALUOp_in(inBus.aluop),
        .ReadData1_in(inBus.rd1), .ReadData2_in(inBus.rd2), .Imm_in(inBus.imm),
        .PCPlus4_in(inBus.pc4), .Rs_in(inBus.rs), .Rt_in(inBus.rt), .Rd_in(inBus.rd),
        .RegDst_ex(sRegDst_ex), .Jump_ex(sJump_ex), .Branch_ex(sBranch_ex),
        .MemRead_ex(sMemRead_ex), .MemtoReg_ex(sMemtoReg_ex), .RegWrite_ex(sRegWrite_ex),
        .ALUSrc_ex(sALUSrc_ex), .Double_ex(sDouble_ex), .D_addi_ex(sD_addi_ex),
        .ALUOp_ex(sALUOp_ex), .ReadData1_ex(sReadData1_ex), .ReadData2_ex(sReadData2_ex),
        .Imm_ex(sImm_ex), .PCPlus4_ex(sPCPlus4_ex), .Rs_ex(sRs_ex), .Rt_ex(sRt_ex),
        .Rd_ex(sRd_ex), .Valid_ex(sValid_ex), .Stall(sStall), .BubbleCount(sBubbleCount)
    );

    // Watchdog so the run always terminates even if the clock stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic instr_t randInstr();
        instr_t r;
        r.regdst   = 2'($urandom_range(0, 3));
        r.jump     = 1'($urandom_range(0, 1));
        r.branch   = 1'($urandom_range(0, 1));
        r.memread  = 1'($urandom_range(0, 1));
        r.memtoreg = 1'($urandom_range(0, 1));
        r.regwrite = 1'($urandom_range(0, 1));
        r.alusrc   = 1'($urandom_range(0, 1));
        r.dbl      = 1'($urandom_range(0, 1));
        r.daddi    = 1'($urandom_range(0, 1));
        r.aluop    = 3'($urandom_range(0, 7));
        r.rd1      = $urandom;
        r.rd2      = $urandom;
        r.imm      = $urandom;
        r.pc4      = $urandom;
        r.rs       = 5'($urandom_range(0, 31));
        r.rt       = 5'($urandom_range(0, 31));
        r.rd       = 5'($urandom_range(0, 31));
        return r;
    endfunction

    // Counters observed through a narrower register read as the true count
    // clipped at that register's maximum.
    function automatic int clip(input int value, input int maxValue);
        return (value > maxValue) ? maxValue : value;
    endfunction

    // Compare every registered output of both instances against the model.
    task automatic checkOutput(input string tag);
        instr_t obs;
        instr_t sObs;
        obs  = {RegDst_ex, Jump_ex, Branch_ex, MemRead_ex, MemtoReg_ex, RegWrite_ex,
                ALUSrc_ex, Double_ex, D_addi_ex, ALUOp_ex, ReadData1_ex, ReadData2_ex,
                Imm_ex, PCPlus4_ex, Rs_ex, Rt_ex, Rd_ex};
        sObs = {sRegDst_ex, sJump_ex, sBranch_ex, sMemRead_ex, sMemtoReg_ex, sRegWrite_ex,
                sALUSrc_ex, sDouble_ex, sD_addi_ex, sALUOp_ex, sReadData1_ex, sReadData2_ex,
                sImm_ex, sPCPlus4_ex, sRs_ex, sRt_ex, sRd_ex};

        checkCount++;
        assert (obs === expEx) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s ex_bundle: got %h expected %h", tag, obs, expEx);
        end

        checkCount++;
        assert (Valid_ex === expValid) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s valid: got %b expected %b", tag, Valid_ex, expValid);
        end

        checkCount++;
        assert (BubbleCount === 16'(clip(expBubbles, 65535))) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s bubble_count: got %0d expected %0d", tag, BubbleCount,
                   clip(expBubbles, 65535));
        end

        checkCount++;
        assert (sObs === expEx && sValid_ex === expValid) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s small_ex: got %h/%b expected %h/%b", tag, sObs, sValid_ex,
                   expEx, expValid);
        end

        checkCount++;
        assert (sBubbleCount === 4'(clip(expBubbles, 15))) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s small_bubble_count: got %0d expected %0d", tag, sBubbleCount,
                   clip(expBubbles, 15));
        end
    endtask

    // Drive one ID-stage cycle, check the combinational stall, advance the
    // model across the clock edge, then check the registered result.
    task automatic applyStimulus(input string tag, input logic rst, input logic flush,
                                 input instr_t ins);
        logic loadUse;
        Rst   = rst;
        Flush = flush;
        inBus = ins;
        #1;

        // The ID instruction reads the register the load in EX is about to
        // write; Rt is a source only for register-register forms.
        loadUse  = expValid && expEx.memread && (expEx.rt != 5'd0)
                   && ((expEx.rt == ins.rs) || (expEx.rt == ins.rt && !ins.alusrc));
        expStall = loadUse && !flush && !rst;

        checkCount++;
        assert (Stall === expStall && sStall === expStall) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s stall: got %b/%b expected %b", tag, Stall, sStall, expStall);
        end

        if (rst) begin
            expEx      = '0;
            expValid   = 1'b0;
            expBubbles = 0;
        end else if (flush || loadUse) begin
            expEx      = '0;
            expValid   = 1'b0;
            expBubbles = expBubbles + 1;
        end else begin
            expEx    = ins;
            expValid = 1'b1;
        end

        @(posedge Clk);
        #1;
        checkOutput(tag);
    endtask

    instr_t ins;
    instr_t lw;
    instr_t add;

    initial begin
        expEx      = '0;
        expValid   = 1'b0;
        expBubbles = 0;
        Rst        = 1'b1;
        Flush      = 1'b0;
        inBus      = '0;
        @(posedge Clk);
        #1;

        // Reset held for two cycles with random inputs
        applyStimulus("reset0", 1'b1, 1'($urandom_range(0, 1)), randInstr());
        applyStimulus("reset1", 1'b1, 1'($urandom_range(0, 1)), randInstr());

        // addi pass-through
        ins          = '0;
        ins.regwrite = 1'b1;
        ins.alusrc   = 1'b1;
        ins.aluop    = 3'b010;
        ins.rd1      = 32'h10;
        ins.imm      = 32'd5;
        ins.rt       = 5'd8;
        applyStimulus("addi_pass", 1'b0, 1'b0, ins);

        // Load-use: lw r8, then add using r8 as Rs
        lw          = '0;
        lw.memread  = 1'b1;
        lw.memtoreg = 1'b1;
        lw.regwrite = 1'b1;
        lw.alusrc   = 1'b1;
        lw.rt       = 5'd8;
        lw.rs       = 5'd3;
        lw.imm      = 32'd4;
        add          = '0;
        add.regwrite = 1'b1;
        add.regdst   = 2'b01;
        add.aluop    = 3'b010;
        add.rs       = 5'd8;
        add.rt       = 5'd9;
        add.rd       = 5'd10;
        add.rd1      = 32'h1234;
        add.rd2      = 32'h5678;
        applyStimulus("lu_load", 1'b0, 1'b0, lw);
        applyStimulus("lu_bubble", 1'b0, 1'b0, add);
        applyStimulus("lu_capture", 1'b0, 1'b0, add);

        // Load-use through Rt of a register-register instruction
        applyStimulus("lu_rt_load", 1'b0, 1'b0, lw);
        ins    = add;
        ins.rs = 5'd2;
        ins.rt = 5'd8;
        applyStimulus("lu_rt_bubble", 1'b0, 1'b0, ins);
        applyStimulus("lu_rt_capture", 1'b0, 1'b0, ins);

        // No false hazard: load to r0 followed by a read of r0
        ins    = lw;
        ins.rt = 5'd0;
        applyStimulus("nf_r0_load", 1'b0, 1'b0, ins);
        ins    = add;
        ins.rs = 5'd0;
        ins.rt = 5'd0;
        applyStimulus("nf_r0_use", 1'b0, 1'b0, ins);

        // No false hazard: addi whose Rt matches is a destination, not a source
        applyStimulus("nf_addi_load", 1'b0, 1'b0, lw);
        ins          = '0;
        ins.regwrite = 1'b1;
        ins.alusrc   = 1'b1;
        ins.aluop    = 3'b010;
        ins.rs       = 5'd9;
        ins.rt       = 5'd8;
        ins.imm      = 32'd7;
        applyStimulus("nf_addi_use", 1'b0, 1'b0, ins);

        // Flush together with a hazard: one bubble, one increment, no stall
        applyStimulus("fh_load", 1'b0, 1'b0, lw);
        applyStimulus("fh_flush", 1'b0, 1'b1, add);
        applyStimulus("fh_next", 1'b0, 1'b0, add);

        // Reset in the middle of a stall, then the held add is captured
        applyStimulus("rs_load", 1'b0, 1'b0, lw);
        applyStimulus("rs_reset", 1'b1, 1'b0, add);
        applyStimulus("rs_capture", 1'b0, 1'b0, add);

        // Saturation: 20 consecutive flushes
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("sat%0d", i), 1'b0, 1'b1, randInstr());
        end
        applyStimulus("sat_reset", 1'b1, 1'b0, randInstr());

        // Randomized traffic, biased towards dependencies on the EX load
        for (int i = 0; i < 400; i++) begin
            logic rRst;
            logic rFlush;
            ins = randInstr();
            if ($urandom_range(0, 1) == 0) ins.rs = expEx.rt;
            if ($urandom_range(0, 3) == 0) ins.rt = expEx.rt;
            rRst   = ($urandom_range(0, 39) == 0);
            rFlush = ($urandom_range(0, 7) == 0);
            applyStimulus($sformatf("rand%0d", i), rRst, rFlush, ins);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
